// File: rtl/game_controller.sv
// -----------------------------------------------------------------------------
// game_controller
//
// Top-level Frogger sequencer. Owns the game phase (IDLE, START, PLAY, DEATH,
// WIN, OVER) and the lives, score, level and car-speed registers. It gates
// frog and lane movement, pulses the frog back to its base tile on every
// entry into START, and blinks o_Flash during the DEATH/WIN/OVER overlays.
// Phase timing is counted in video frames using i_Frame_Tick.
//
// Ports
//   i_Clk          system clock
//   i_Reset        asynchronous, active-high reset
//   i_Frame_Tick   one-cycle pulse per video frame
//   i_Start        debounced start switch (level)
//   i_Has_Collided frog/car overlap (level)
//   i_Goal         frog on goal row (level)
//   o_State        current phase (IDLE=0 .. OVER=5)
//   o_Frog_Reset   one-cycle pulse on the first START cycle
//   o_Move_Enable  frog movement allowed (PLAY only)
//   o_Lanes_Enable car movement allowed (PLAY only)
//   o_Level        current level, 1..c_MAX_LEVEL
//   o_Lives        remaining lives
//   o_Score        goals reached, saturating at 99
//   o_Car_Speed    lane speed in pixels/frame, min(level, 7)
//   o_Flash        overlay blink signal
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module game_controller #(
    parameter int unsigned c_LIVES_INI    = 3,
    parameter int unsigned c_MAX_LEVEL    = 9,
    parameter int unsigned c_DEATH_FRAMES = 60,
    parameter int unsigned c_WIN_FRAMES   = 90,
    parameter int unsigned c_FLASH_FRAMES = 8
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Frame_Tick,
    input  logic       i_Start,
    input  logic       i_Has_Collided,
    input  logic       i_Goal,
    output logic [2:0] o_State,
    output logic       o_Frog_Reset,
    output logic       o_Move_Enable,
    output logic       o_Lanes_Enable,
    output logic [3:0] o_Level,
    output logic [1:0] o_Lives,
    output logic [6:0] o_Score,
    output logic [2:0] o_Car_Speed,
    output logic       o_Flash
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_PLAY  = 3'd2,
        S_DEATH = 3'd3,
        S_WIN   = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam logic [1:0] c_LIVES_LD   = 2'(c_LIVES_INI);
    localparam logic [3:0] c_LEVEL_MAX  = 4'(c_MAX_LEVEL);
    // Counters hold "ticks seen so far", so the phase ends on the tick that
    // finds the counter at FRAMES-1.
    localparam logic [7:0] c_DEATH_LAST = 8'(c_DEATH_FRAMES - 1);
    localparam logic [7:0] c_WIN_LAST   = 8'(c_WIN_FRAMES - 1);
    localparam logic [7:0] c_FLASH_LAST = 8'(c_FLASH_FRAMES - 1);
    localparam logic [6:0] c_SCORE_MAX  = 7'd99;

    // Registered state
    state_t     r_state;
    logic       r_start_q;
    logic [3:0] r_level;
    logic [1:0] r_lives;
    logic [6:0] r_score;
    logic [2:0] r_speed;
    logic       r_frog_reset;
    logic       r_move_en;
    logic       r_lanes_en;
    logic       r_flash;
    logic [7:0] r_frame_cnt;
    logic [7:0] r_flash_cnt;

    // Next-state values
    state_t     w_next_state;
    logic       w_start_edge;
    logic       w_frame_done;
    logic       w_cur_flashing;
    logic       w_next_flashing;
    logic [3:0] w_level_d;
    logic [1:0] w_lives_d;
    logic [6:0] w_score_d;
    logic [2:0] w_speed_d;
    logic [7:0] w_frame_cnt_d;
    logic [7:0] w_flash_cnt_d;
    logic       w_flash_d;
    logic       w_frog_reset_d;
    logic       w_play_d;

    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned; otherwise a latch would be inferred.
        w_next_state  = r_state;
        w_level_d     = r_level;
        w_lives_d     = r_lives;
        w_score_d     = r_score;
        w_speed_d     = r_speed;
        w_flash_d     = r_flash;
        w_flash_cnt_d = r_flash_cnt;
        w_frame_cnt_d = r_frame_cnt;

        // start_q resets to 1, so a switch held through reset never looks
        // like a fresh press.
        w_start_edge = i_Start & ~r_start_q;

        w_frame_done = i_Frame_Tick &&
                       (((r_state == S_DEATH) && (r_frame_cnt == c_DEATH_LAST)) ||
                        ((r_state == S_WIN)   && (r_frame_cnt == c_WIN_LAST)));

        case (r_state)
            S_IDLE, S_OVER: begin
                if (w_start_edge) begin
                    w_next_state = S_START;
                    w_level_d    = 4'd1;
                    w_lives_d    = c_LIVES_LD;
                    w_score_d    = 7'd0;
                    w_speed_d    = 3'd1;
                end
            end
            S_START: begin
                if (i_Frame_Tick) begin
                    w_next_state = S_PLAY;
                end
            end
            S_PLAY: begin
                // Collision outranks a simultaneous goal.
                if (i_Has_Collided) begin
                    w_next_state = S_DEATH;
                    if (r_lives != 2'd0) begin
                        w_lives_d = r_lives - 2'd1;
                    end
                end else if (i_Goal) begin
                    w_next_state = S_WIN;
                    if (r_score != c_SCORE_MAX) begin
                        w_score_d = r_score + 7'd1;
                    end
                end
            end
            S_DEATH: begin
                if (w_frame_done) begin
                    w_next_state = (r_lives == 2'd0) ? S_OVER : S_START;
                end
            end
            S_WIN: begin
                if (w_frame_done) begin
                    w_next_state = S_START;
                    if (r_level != c_LEVEL_MAX) begin
                        w_level_d = r_level + 4'd1;
                    end
                    w_speed_d = (w_level_d > 4'd7) ? 3'd7 : w_level_d[2:0];
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // Frame counter: cleared on every state entry, counts ticks only in
        // the timed phases.
        if (w_next_state != r_state) begin
            w_frame_cnt_d = 8'd0;
        end else if (i_Frame_Tick && ((r_state == S_DEATH) || (r_state == S_WIN))) begin
            w_frame_cnt_d = r_frame_cnt + 8'd1;
        end

        // Flash keeps running across DEATH->OVER; any other destination
        // clears it.
        w_cur_flashing  = (r_state == S_DEATH) || (r_state == S_WIN) || (r_state == S_OVER);
        w_next_flashing = (w_next_state == S_DEATH) || (w_next_state == S_WIN) ||
                          (w_next_state == S_OVER);
        if (!w_next_flashing) begin
            w_flash_d     = 1'b0;
            w_flash_cnt_d = 8'd0;
        end else if (w_cur_flashing && i_Frame_Tick) begin
            if (r_flash_cnt == c_FLASH_LAST) begin
                w_flash_d     = ~r_flash;
                w_flash_cnt_d = 8'd0;
            end else begin
                w_flash_cnt_d = r_flash_cnt + 8'd1;
            end
        end

        // Outputs are derived from the next state so they line up with
        // o_State in the same cycle.
        w_frog_reset_d = (w_next_state == S_START) && (r_state != S_START);
        w_play_d       = (w_next_state == S_PLAY);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state      <= S_IDLE;
            r_start_q    <= 1'b1;
            r_level      <= 4'd1;
            r_lives      <= c_LIVES_LD;
            r_score      <= 7'd0;
            r_speed      <= 3'd1;
            r_frog_reset <= 1'b0;
            r_move_en    <= 1'b0;
            r_lanes_en   <= 1'b0;
            r_flash      <= 1'b0;
            r_frame_cnt  <= 8'd0;
            r_flash_cnt  <= 8'd0;
        end else begin
            r_state      <= w_next_state;
            r_start_q    <= i_Start;
            r_level      <= w_level_d;
            r_lives      <= w_lives_d;
            r_score      <= w_score_d;
            r_speed      <= w_speed_d;
            r_frog_reset <= w_frog_reset_d;
            r_move_en    <= w_play_d;
            r_lanes_en   <= w_play_d;
            r_flash      <= w_flash_d;
            r_frame_cnt  <= w_frame_cnt_d;
            r_flash_cnt  <= w_flash_cnt_d;
        end
    end

    assign o_State        = r_state;
    assign o_Frog_Reset   = r_frog_reset;
    assign o_Move_Enable  = r_move_en;
    assign o_Lanes_Enable = r_lanes_en;
    assign o_Level        = r_level;
    assign o_Lives        = r_lives;
    assign o_Score        = r_score;
    assign o_Car_Speed    = r_speed;
    assign o_Flash        = r_flash;

endmodule

// File: doc/game_controller.md
# game_controller

Top-level sequencer for the Frogger game: it owns the game phase (title, play, death, level-won, game over) plus the lives, score, level and car-speed registers. It sits between the debounced switch and collision/goal detectors and the frog movement, lane and display blocks. It gates movement, pulses the frog back to its base tile, and configures lane speed from the current level. Phase timing is counted in video frames via a one-cycle frame strobe derived from the VGA timing.

## Interface
- c_LIVES_INI, 3: lives loaded at game start (1..3).
- c_MAX_LEVEL, 9: level saturation value (1..15).
- c_DEATH_FRAMES, 60: frames spent in DEATH (1..255).
- c_WIN_FRAMES, 90: frames spent in WIN (1..255).
- c_FLASH_FRAMES, 8: frames per o_Flash half-period (1..255).

- i_Clk  in  1  system clock, the single clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Frame_Tick  in  1  one-cycle pulse per video frame (start of vertical blanking).
- i_Start  in  1  debounced start switch, level.
- i_Has_Collided  in  1  frog/car overlap, level.
- i_Goal  in  1  frog on goal row, level.
- o_State  out  3  IDLE=0, START=1, PLAY=2, DEATH=3, WIN=4, OVER=5.
- o_Frog_Reset  out  1  one-cycle pulse that returns the frog to its base position.
- o_Move_Enable  out  1  frog movement allowed.
- o_Lanes_Enable  out  1  car movement allowed.
- o_Level  out  4  current level, 1..c_MAX_LEVEL.
- o_Lives  out  2  remaining lives.
- o_Score  out  7  goals reached, 0..99.
- o_Car_Speed  out  3  pixels per frame for the lanes: min(o_Level, 7).
- o_Flash  out  1  blink signal for display overlays.

## Operation
- Start edge detection: start_edge = i_Start & ~start_q. start_q resets to 1, so a switch already held through reset does not start a game.
- Reset values:
  - State: IDLE.
  - Counters: level=1, lives=c_LIVES_INI, score=0, speed=1.
  - Outputs: o_Frog_Reset=0, both enables 0, o_Flash=0.
  - Frame counter and flash counter: 0.
- IDLE: on start_edge go to START and load level=1, lives=c_LIVES_INI, score=0.
- START: waits for i_Frame_Tick, then goes to PLAY. o_Frog_Reset is high for the first START cycle only. Collision, goal and start inputs are ignored.
- PLAY: o_Move_Enable=1 and o_Lanes_Enable=1. The first sampled event wins:
  - i_Has_Collided: go to DEATH and decrement lives. Collision has priority over a simultaneous i_Goal.
  - i_Goal: go to WIN and increment score, saturating at 99.
- DEATH: enables 0. The frame counter counts i_Frame_Tick. When the count reaches c_DEATH_FRAMES, go to OVER if lives==0, otherwise go to START.
- WIN: enables 0. When the frame count reaches c_WIN_FRAMES, increment level (saturating at c_MAX_LEVEL), update speed, and go to START.
- OVER: enables 0. start_edge reloads level/lives/score exactly as in IDLE and goes to START.
- start_edge in START, PLAY, DEATH or WIN is ignored.
- Frame counter: 8 bits, cleared on every state entry.
- o_Flash: toggles every c_FLASH_FRAMES ticks while in DEATH, WIN or OVER. It is forced to 0 (and its counter cleared) in all other states.
- Lives never underflow. Decrement happens only in PLAY, and PLAY is unreachable with lives==0.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- An event sampled in cycle N produces the new o_State and counter values in cycle N+1.
- o_Frog_Reset is high in the cycle where o_State first reads START, for exactly one cycle. This also holds on START→START re-entry paths.
- o_Car_Speed updates in the same cycle as o_Level.
- Enables drop in the same cycle o_State leaves PLAY.
- DEATH lasts exactly c_DEATH_FRAMES frame ticks after entry. A tick in the entry cycle is not counted.
- i_Reset asserted mid-phase returns every register to its reset value immediately (asynchronously); the next rising edge sees IDLE.

## Test plan
- Boot with i_Start held high through reset and after release → stays IDLE. Release i_Start, then press → START within 1 cycle, o_Frog_Reset one-cycle pulse, PLAY on next frame tick, o_Lives=3, o_Score=0, o_Level=1, o_Car_Speed=1.
- In PLAY assert i_Has_Collided and i_Goal in the same cycle → DEATH, o_Lives=2, o_Score unchanged, enables 0 next cycle. With c_DEATH_FRAMES=4 → START exactly after the 4th tick.
- Three collisions from lives=3 → after the third DEATH times out, OVER with o_Lives=0. o_Flash toggles every 8 ticks. start_edge → START with o_Lives=3, o_Score=0, o_Level=1.
- Ten goals with c_MAX_LEVEL=9 → o_Score=10, o_Level saturates at 9 after the 8th win, o_Car_Speed=7 from level 7 on.
- Score saturation: preload 99 goals (or force) → further goal keeps o_Score=99, state still goes to WIN.
- Assert i_Reset for 1 cycle mid-WIN, not aligned to a clock edge → all outputs return to reset values immediately; no o_Frog_Reset pulse follows.
